facto_sched: RTL and testbench

FACTO_SCHED -- requirements
Module: facto_sched

---
 rtl/facto_sched_pkg.sv | 28 ++
 rtl/facto_sched_rr_arb2.sv | 29 ++
 rtl/facto_sched.sv | 187 ++++++++++++++++++
 tb/tb_facto_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/facto_sched_pkg.sv
// Shared types and constants for the factorial-core job scheduler.
package facto_sched_pkg;

    localparam int DATA_W = 64;

    // Core register offsets, added to the instance base address
    localparam logic [15:0] OFF_OPSTART  = 16'h0000;
    localparam logic [15:0] OFF_OPCLEAR  = 16'h0008;
    localparam logic [15:0] OFF_OPDONE   = 16'h0010;
    localparam logic [15:0] OFF_INTREN   = 16'h0018;
    localparam logic [15:0] OFF_OPERAND  = 16'h0020;
    localparam logic [15:0] OFF_RESULT_H = 16'h0028;
    localparam logic [15:0] OFF_RESULT_L = 16'h0030;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR_HI,
        S_CLR_LO,
        S_INTR,
        S_OPND,
        S_START,
        S_WAIT,
        S_RD_H,
        S_RD_L,
        S_DONE
    } state_t;

endpackage

// File: rtl/facto_sched_rr_arb2.sv
// Two-way round-robin arbiter: the pointer favours the requester not
// granted last; the pointer only advances when a grant is taken.
module facto_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic       grant,
    output logic       valid
);

    logic ptr_q;

    // Pointer wins a tie; otherwise whichever requester is active
    always_comb begin
        valid = |req;
        grant = req[ptr_q] ? ptr_q : ~ptr_q;
    end

    // Move the pointer past the requester that was just served
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (take && valid) begin
            ptr_q <= ~grant;
        end
    end

endmodule

// File: rtl/facto_sched.sv
// Factorial-core job scheduler: arbitrates two requesters, drives the core
// register bus through clear/setup/start/wait/readback, returns the result.
// Optional macro FACTO_SCHED_INTR_EN: wait for m_intr instead of polling opdone.
module facto_sched
    import facto_sched_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'h7000,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] op0,
    input  logic [DATA_W-1:0] op1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] res_h,
    output logic [DATA_W-1:0] res_l,
    output logic              err,
    output logic              busy,
    output logic              m_sel,
    output logic              m_wr,
    output logic [15:0]       m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_intr
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

`ifdef FACTO_SCHED_INTR_EN
    localparam logic [DATA_W-1:0] INTREN_VAL = 64'd1;
`else
    localparam logic [DATA_W-1:0] INTREN_VAL = 64'd0;
`endif

    state_t            state, state_nxt;
    logic [DATA_W-1:0] opnd_q;
    logic              gnt_q;
    logic              phase_q;
    logic              tout_q;
    logic [TW-1:0]     tcnt_q;
    logic              arb_grant, arb_valid;
    logic              done_seen, tout_hit;

    facto_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .take  (state == S_IDLE),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    // Completion detect and timeout detect for the WAIT state
    always_comb begin
`ifdef FACTO_SCHED_INTR_EN
        done_seen = m_intr;
`else
        done_seen = phase_q & m_rdata[0];
`endif
        tout_hit = (tcnt_q == TW'(TIMEOUT_CYC - 1));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and bus/handshake outputs
    always_comb begin
        state_nxt = state;
        m_sel     = 1'b0;
        m_wr      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        ack       = '0;
        busy      = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (arb_valid) state_nxt = S_CLR_HI;
            end
            S_CLR_HI: begin
                m_sel = 1'b1; m_wr = 1'b1;
                m_addr = BASE_ADDR + OFF_OPCLEAR; m_wdata = 64'd1;
                state_nxt = S_CLR_LO;
            end
            S_CLR_LO: begin
                m_sel = 1'b1; m_wr = 1'b1;
                m_addr = BASE_ADDR + OFF_OPCLEAR; m_wdata = 64'd0;
                // The clear pair also serves the timeout abort path
                state_nxt = tout_q ? S_DONE : S_INTR;
            end
            S_INTR: begin
                m_sel = 1'b1; m_wr = 1'b1;
                m_addr = BASE_ADDR + OFF_INTREN; m_wdata = INTREN_VAL;
                state_nxt = S_OPND;
            end
            S_OPND: begin
                m_sel = 1'b1; m_wr = 1'b1;
                m_addr = BASE_ADDR + OFF_OPERAND; m_wdata = opnd_q;
                state_nxt = S_START;
            end
            S_START: begin
                m_sel = 1'b1; m_wr = 1'b1;
                m_addr = BASE_ADDR + OFF_OPSTART; m_wdata = 64'd1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
`ifndef FACTO_SCHED_INTR_EN
                m_sel  = 1'b1;
                m_addr = BASE_ADDR + OFF_OPDONE;
`endif
                if (done_seen)     state_nxt = S_RD_H;
                else if (tout_hit) state_nxt = S_CLR_HI;
            end
            S_RD_H: begin
                m_sel  = 1'b1;
                m_addr = BASE_ADDR + OFF_RESULT_H;
                if (phase_q) state_nxt = S_RD_L;
            end
            S_RD_L: begin
                m_sel  = 1'b1;
                m_addr = BASE_ADDR + OFF_RESULT_L;
                if (phase_q) state_nxt = S_DONE;
            end
            S_DONE: begin
                ack       = gnt_q ? 2'b10 : 2'b01;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Job context, two-cycle read phase, timeout counter and result capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opnd_q  <= '0;
            gnt_q   <= 1'b0;
            phase_q <= 1'b0;
            tout_q  <= 1'b0;
            tcnt_q  <= '0;
            res_h   <= '0;
            res_l   <= '0;
            err     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (arb_valid) begin
                        opnd_q  <= arb_grant ? op1 : op0;
                        gnt_q   <= arb_grant;
                        tout_q  <= 1'b0;
                        err     <= 1'b0;
                        phase_q <= 1'b0;
                    end
                end
                S_START: begin
                    tcnt_q  <= '0;
                    phase_q <= 1'b0;
                end
                S_WAIT: begin
                    tcnt_q  <= tcnt_q + TW'(1);
                    phase_q <= (done_seen || tout_hit) ? 1'b0 : ~phase_q;
                    if (!done_seen && tout_hit) begin
                        tout_q <= 1'b1;
                        err    <= 1'b1;
                        res_h  <= '0;
                        res_l  <= '0;
                    end
                end
                S_RD_H: begin
                    phase_q <= ~phase_q;
                    if (phase_q) res_h <= m_rdata;
                end
                S_RD_L: begin
                    phase_q <= ~phase_q;
                    if (phase_q) res_l <= m_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_facto_sched.sv
// Self-checking bench for facto_sched with a behavioural factorial core stub.
module tb_facto_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [63:0] op0, op1;
    logic [1:0]  ack;
    logic [63:0] res_h, res_l;
    logic        err, busy;
    logic        m_sel, m_wr;
    logic [15:0] m_addr;
    logic [63:0] m_wdata, m_rdata;
    logic        m_intr;

    int checks = 0;
    int errors = 0;

`ifdef FACTO_SCHED_INTR_EN
    localparam logic [63:0] INTRV = 64'd1;
`else
    localparam logic [63:0] INTRV = 64'd0;
`endif

    always #5 clk = ~clk;

    facto_sched #(.BASE_ADDR(16'h7000), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .req(req), .op0(op0), .op1(op1),
        .ack(ack), .res_h(res_h), .res_l(res_l), .err(err), .busy(busy),
        .m_sel(m_sel), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_intr(m_intr)
    );

    function automatic logic [127:0] fact(input logic [63:0] n);
        logic [127:0] r;
        r = 128'd1;
        for (longint unsigned i = 2; i <= n; i++) r = r * 128'(i);
        return r;
    endfunction

    // ---------------- core stub ----------------
    logic [127:0] c_res = '0;
    logic [63:0]  c_opnd = '0;
    logic         c_done = 1'b0;
    logic         c_intren = 1'b0;
    int           c_cnt = 0;
    bit           stub_never = 1'b0;
    int           lat = 3;

    always @(posedge clk) begin
        if (c_cnt > 0) begin
            c_cnt <= c_cnt - 1;
            if (c_cnt == 1) c_done <= 1'b1;
        end
        if (m_sel && m_wr) begin
            case (m_addr)
                16'h7008: if (m_wdata[0]) begin c_done <= 1'b0; c_res <= '0; c_cnt <= 0; end
                16'h7018: c_intren <= m_wdata[0];
                16'h7020: c_opnd <= m_wdata;
                16'h7000: if (m_wdata[0]) begin
                    c_done <= 1'b0;
                    if (!stub_never) begin
                        c_res <= fact(c_opnd);
                        c_cnt <= lat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_intr  = c_done & c_intren;
    assign m_rdata = (m_sel && !m_wr) ?
                     ((m_addr == 16'h7010) ? {63'd0, c_done} :
                      (m_addr == 16'h7028) ? c_res[127:64] :
                      (m_addr == 16'h7030) ? c_res[63:0] : 64'd0) : 64'd0;

    // ---------------- bus write log ----------------
    typedef struct { logic [15:0] a; logic [63:0] d; } wr_t;
    wr_t wlog[$];

    always @(negedge clk) begin
        if (m_sel && m_wr) wlog.push_back('{a: m_addr, d: m_wdata});
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_writes(input string tag, input logic [63:0] op, input bit tout);
        wr_t exp[$];
        exp.push_back('{a: 16'h7008, d: 64'd1});
        exp.push_back('{a: 16'h7008, d: 64'd0});
        exp.push_back('{a: 16'h7018, d: INTRV});
        exp.push_back('{a: 16'h7020, d: op});
        exp.push_back('{a: 16'h7000, d: 64'd1});
        if (tout) begin
            exp.push_back('{a: 16'h7008, d: 64'd1});
            exp.push_back('{a: 16'h7008, d: 64'd0});
        end
        chk({tag, "_nwr"}, 128'(wlog.size()), 128'(exp.size()));
        for (int i = 0; i < exp.size() && i < wlog.size(); i++) begin
            chk($sformatf("%s_wr%0d_addr", tag, i), 128'(wlog[i].a), 128'(exp[i].a));
            chk($sformatf("%s_wr%0d_data", tag, i), 128'(wlog[i].d), 128'(exp[i].d));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ack"}, 128'(ack), 0);
        chk({tag, "_busy"}, 128'(busy), 0);
        chk({tag, "_m_sel"}, 128'(m_sel), 0);
        chk({tag, "_m_wr"}, 128'(m_wr), 0);
        chk({tag, "_m_addr"}, 128'(m_addr), 0);
        chk({tag, "_m_wdata"}, 128'(m_wdata), 0);
        chk({tag, "_res_h"}, 128'(res_h), 0);
        chk({tag, "_res_l"}, 128'(res_l), 0);
        chk({tag, "_err"}, 128'(err), 0);
    endtask

    // Present a request and wait (bounded) for the ack pulse
    task automatic run_job(input logic [1:0] r, input logic [63:0] o0, input logic [63:0] o1,
                           input bit hold, output logic [1:0] a, output logic [63:0] h,
                           output logic [63:0] l, output logic e, output bit ok);
        wlog.delete();
        req = r; op0 = o0; op1 = o1;
        ok = 1'b0; a = '0; h = '0; l = '0; e = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (ack != 2'b00) begin
                a = ack; h = res_h; l = res_l; e = err; ok = 1'b1;
                break;
            end
        end
        if (!hold) req = 2'b00;
        if (!ok) chk("ack_wait_bound", 0, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  rq;
        logic [63:0] op;
        logic [1:0]  exp_ack;
        logic [63:0] exp_h;
        logic [63:0] exp_l;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [1:0]  a;
        logic [63:0] h, l, o0, o1, op;
        logic        e;
        bit          ok, found, g, ptr, tout;
        int          nack;
        logic [127:0] f;

        vecs[0] = '{2'b01, 64'd5,  2'b01, 64'd0, 64'd120};
        vecs[1] = '{2'b01, 64'd0,  2'b01, 64'd0, 64'd1};
        vecs[2] = '{2'b01, 64'd1,  2'b01, 64'd0, 64'd1};
        vecs[3] = '{2'b10, 64'd19, 2'b10, 64'd0, 64'h01B02B9306890000};
        vecs[4] = '{2'b10, 64'd20, 2'b10, 64'd0, 64'h21C3677C82B40000};
        vecs[5] = '{2'b01, 64'd21, 2'b01, 64'd2, 64'hC5077D36B8C40000};

        reset = 1'b1; req = 2'b00; op0 = '0; op1 = '0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) reset = 1'b0;

        // Table-driven single-requester jobs
        foreach (vecs[k]) begin
            o0 = (vecs[k].rq == 2'b01) ? vecs[k].op : {$urandom, $urandom};
            o1 = (vecs[k].rq == 2'b10) ? vecs[k].op : {$urandom, $urandom};
            lat = $urandom_range(1, 8);
            run_job(vecs[k].rq, o0, o1, 1'b0, a, h, l, e, ok);
            chk($sformatf("vec%0d_ack", k), 128'(a), 128'(vecs[k].exp_ack));
            chk($sformatf("vec%0d_res_h", k), 128'(h), 128'(vecs[k].exp_h));
            chk($sformatf("vec%0d_res_l", k), 128'(l), 128'(vecs[k].exp_l));
            chk($sformatf("vec%0d_err", k), 128'(e), 0);
            check_writes($sformatf("vec%0d", k), vecs[k].op, 1'b0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_idle_busy", k), 128'(busy), 0);
            chk($sformatf("vec%0d_idle_ack", k), 128'(ack), 0);
            chk($sformatf("vec%0d_idle_sel", k), 128'({m_sel, m_wr, m_addr}), 0);
        end

        // Both requesters held across three jobs from reset: grants 0,1,0
        pulse_reset();
        lat = 2;
        run_job(2'b11, 64'd3, 64'd4, 1'b1, a, h, l, e, ok);
        chk("rr0_ack", 128'(a), 128'(2'b01));
        chk("rr0_res_l", 128'(l), 6);
        run_job(2'b11, 64'd3, 64'd4, 1'b1, a, h, l, e, ok);
        chk("rr1_ack", 128'(a), 128'(2'b10));
        chk("rr1_res_l", 128'(l), 24);
        run_job(2'b11, 64'd3, 64'd4, 1'b0, a, h, l, e, ok);
        chk("rr2_ack", 128'(a), 128'(2'b01));
        chk("rr2_res_l", 128'(l), 6);

        // Core never finishes: timeout abort with clear pair
        stub_never = 1'b1;
        run_job(2'b01, 64'd7, 64'd9, 1'b0, a, h, l, e, ok);
        chk("tout_ack", 128'(a), 128'(2'b01));
        chk("tout_err", 128'(e), 1);
        chk("tout_res_l", 128'(l), 0);
        chk("tout_res_h", 128'(h), 0);
        check_writes("tout", 64'd7, 1'b1);

        // Reset while waiting for the core
        wlog.delete();
        req = 2'b01; op0 = 64'd5;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (m_sel && m_wr && m_addr == 16'h7000) begin found = 1'b1; break; end
        end
        chk("rst_wait_start_seen", 128'(found), 1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1 check_all_zero("rst_mid");
        @(negedge clk); reset = 1'b0; req = 2'b00;
        nack = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ack != 2'b00) nack++;
        end
        chk("rst_no_ack", 128'(nack), 0);
        stub_never = 1'b0;
        lat = 4;
        run_job(2'b01, 64'd5, 64'd0, 1'b0, a, h, l, e, ok);
        chk("post_rst_ack", 128'(a), 128'(2'b01));
        chk("post_rst_res_l", 128'(l), 120);
        chk("post_rst_err", 128'(e), 0);
        check_writes("post_rst", 64'd5, 1'b0);

        // Randomised jobs against a round-robin/factorial reference
        pulse_reset();
        ptr = 1'b0;
        for (int n = 0; n < 40; n++) begin
            logic [1:0] r;
            r = 2'($urandom_range(1, 3));
            tout = ($urandom_range(0, 5) == 0);
            stub_never = tout;
            lat = $urandom_range(1, 10);
            if (tout) begin
                o0 = {$urandom, $urandom};
                o1 = {$urandom, $urandom};
            end else begin
                o0 = 64'($urandom_range(0, 34));
                o1 = 64'($urandom_range(0, 34));
            end
            g = (r == 2'b11) ? ptr : (r == 2'b10);
            ptr = ~g;
            op = g ? o1 : o0;
            f = tout ? 128'd0 : fact(op);
            run_job(r, o0, o1, 1'b0, a, h, l, e, ok);
            chk($sformatf("rnd%0d_ack", n), 128'(a), g ? 128'(2'b10) : 128'(2'b01));
            chk($sformatf("rnd%0d_res", n), {h, l}, f);
            chk($sformatf("rnd%0d_err", n), 128'(e), 128'(tout));
            check_writes($sformatf("rnd%0d", n), op, tout);
        end
        stub_never = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
